// File: rtl/dpram_pkg.sv
// Shared types and default sizes for the dual-port RAM arbiter slice.
package dpram_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 16;
  localparam int CW_DEF = 8;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  // Canonical requester bundle at the default widths; the top re-declares it at its own widths.
  typedef struct packed {
    logic              we;
    logic [AW_DEF-1:0] addr;
    logic [DW_DEF-1:0] wdata;
  } req_t;

endpackage

// File: rtl/dpram_rr_arb.sv
// Two-input round-robin arbiter; req[0]/gnt[0] is port A, req[1]/gnt[1] is port B.
// Define DPRAM_ARB_FIXED_PRIO_EN to make A win every tie and drop the pointer register.
module dpram_rr_arb
  import dpram_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

`ifdef DPRAM_ARB_FIXED_PRIO_EN

  always_comb begin
    gnt = '0;
    if (rst_n) begin
      gnt[0] = req[0];
      gnt[1] = req[1] & ~req[0];
    end
  end

`else

  port_e last_q, last_d;

  // Grants are suppressed while reset is held so nothing reaches the RAM.
  always_comb begin
    gnt = '0;
    if (rst_n) begin
      if (req[0] && (!req[1] || last_q == PORT_B)) begin
        gnt[0] = 1'b1;
      end else if (req[1]) begin
        gnt[1] = 1'b1;
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (gnt[0]) begin
      last_d = PORT_A;
    end else if (gnt[1]) begin
      last_d = PORT_B;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= PORT_B;
    end else begin
      last_q <= last_d;
    end
  end

`endif

endmodule

// File: rtl/dpram_arbiter.sv
// Shares one single-port synchronous RAM between requester ports A and B.
// Optional macro DPRAM_ARB_FIXED_PRIO_EN (in dpram_rr_arb) gives A fixed priority on ties.
module dpram_arbiter
  import dpram_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic [CW-1:0] conflict_cnt
);

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } port_req_t;

  port_req_t     a_pkt, b_pkt, sel_pkt;
  port_e         sel;
  logic [1:0]    gnt;
  logic          a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
  logic [DW-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign a_pkt = '{we: a_we, addr: a_addr, wdata: a_wdata};
  assign b_pkt = '{we: b_we, addr: b_addr, wdata: b_wdata};

  dpram_rr_arb u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({b_req, a_req}),
    .gnt   (gnt)
  );

  assign a_gnt = gnt[0];
  assign b_gnt = gnt[1];

  // Idle cycles leave the mux on port A; only ram_we is forced low.
  always_comb begin
    sel       = b_gnt ? PORT_B : PORT_A;
    sel_pkt   = (sel == PORT_B) ? b_pkt : a_pkt;
    ram_en    = |gnt;
    ram_we    = ram_en & sel_pkt.we;
    ram_addr  = sel_pkt.addr;
    ram_wdata = sel_pkt.wdata;
  end

  // RAM data is already registered, so it is passed straight through in the rvalid cycle and held after.
  always_comb begin
    a_rvalid_d = a_gnt & ~a_we;
    b_rvalid_d = b_gnt & ~b_we;
    a_rdata    = a_rvalid_q ? ram_rdata : a_rdata_q;
    b_rdata    = b_rvalid_q ? ram_rdata : b_rdata_q;
    a_rdata_d  = a_rdata;
    b_rdata_d  = b_rdata;
    cnt_d      = cnt_q;
    if (a_req && b_req && (cnt_q != {CW{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
      cnt_q      <= '0;
    end else begin
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
      cnt_q      <= cnt_d;
    end
  end

  assign a_rvalid     = a_rvalid_q;
  assign b_rvalid     = b_rvalid_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_dpram_arbiter.sv
// Directed self-checking bench for dpram_arbiter with a write-first RAM model.
module tb_dpram_arbiter;

  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic [7:0]    conflict_cnt;

  logic          a_gnt4, a_rvalid4, b_gnt4, b_rvalid4, ram_en4, ram_we4;
  logic [DW-1:0] a_rdata4, b_rdata4, ram_wdata4;
  logic [AW-1:0] ram_addr4;
  logic [3:0]    conflict_cnt4;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dpram_arbiter #(.AW(AW), .DW(DW), .CW(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .conflict_cnt(conflict_cnt)
  );

  dpram_arbiter #(.AW(AW), .DW(DW), .CW(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt4), .a_rvalid(a_rvalid4), .a_rdata(a_rdata4),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt4), .b_rvalid(b_rvalid4), .b_rdata(b_rdata4),
    .ram_en(ram_en4), .ram_we(ram_we4), .ram_addr(ram_addr4), .ram_wdata(ram_wdata4),
    .ram_rdata(ram_rdata), .conflict_cnt(conflict_cnt4)
  );

  // Write-first single-port RAM, one-cycle read latency.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        mem[ram_addr] <= ram_wdata;
        ram_rdata     <= ram_wdata;
      end else begin
        ram_rdata <= mem[ram_addr];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic req, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    a_req = req; a_we = we; a_addr = addr; a_wdata = wd;
  endtask

  task automatic set_b(input logic req, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    b_req = req; b_we = we; b_addr = addr; b_wdata = wd;
  endtask

  task automatic do_reset();
    set_a(0, 0, '0, '0);
    set_b(0, 0, '0, '0);
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_a(1, 1, 8'h01, 16'h1111);
    set_b(1, 0, 8'h02, 16'h2222);
    step();
    #3;
    checks++; if (a_gnt !== 1'b0) begin failures++; $display("FAIL rst_a_gnt got=%b exp=0", a_gnt); end
    checks++; if (b_gnt !== 1'b0) begin failures++; $display("FAIL rst_b_gnt got=%b exp=0", b_gnt); end
    checks++; if (ram_en !== 1'b0) begin failures++; $display("FAIL rst_ram_en got=%b exp=0", ram_en); end
    checks++; if ({a_rvalid, b_rvalid} !== 2'b00) begin failures++; $display("FAIL rst_rvalid got=%b exp=00", {a_rvalid, b_rvalid}); end
    checks++; if (a_rdata !== 16'h0 || b_rdata !== 16'h0) begin failures++; $display("FAIL rst_rdata got=%h/%h exp=0000/0000", a_rdata, b_rdata); end
    checks++; if (conflict_cnt !== 8'd0) begin failures++; $display("FAIL rst_cnt got=%0d exp=0", conflict_cnt); end
    do_reset();
  endtask

  task automatic test_write_read();
    do_reset();
    set_a(1, 1, 8'h05, 16'h1234);
    #3;
    checks++; if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin failures++; $display("FAIL wr_gnt got=%b%b exp=10", a_gnt, b_gnt); end
    checks++; if (ram_we !== 1'b1 || ram_addr !== 8'h05 || ram_wdata !== 16'h1234) begin failures++; $display("FAIL wr_ram got=%b/%h/%h exp=1/05/1234", ram_we, ram_addr, ram_wdata); end
    step();
    set_a(1, 0, 8'h05, 16'h0000);
    #3;
    checks++; if (a_gnt !== 1'b1) begin failures++; $display("FAIL rd_a_gnt got=%b exp=1", a_gnt); end
    checks++; if (a_rvalid !== 1'b0) begin failures++; $display("FAIL wr_no_rvalid got=%b exp=0", a_rvalid); end
    checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL rd_ram_we got=%b exp=0", ram_we); end
    step();
    set_a(0, 0, '0, '0);
    #3;
    checks++; if (a_rvalid !== 1'b1 || a_rdata !== 16'h1234) begin failures++; $display("FAIL rd_a_data got=%b/%h exp=1/1234", a_rvalid, a_rdata); end
    checks++; if (b_rvalid !== 1'b0) begin failures++; $display("FAIL rd_no_b_rvalid got=%b exp=0", b_rvalid); end
    checks++; if (ram_en !== 1'b0 || ram_we !== 1'b0) begin failures++; $display("FAIL idle_ram got=%b%b exp=00", ram_en, ram_we); end
    step();
    #3;
    checks++; if (a_rvalid !== 1'b0 || a_rdata !== 16'h1234) begin failures++; $display("FAIL rd_hold got=%b/%h exp=0/1234", a_rvalid, a_rdata); end
  endtask

  task automatic test_back_to_back();
    logic exp_a;
    do_reset();
    set_a(1, 0, 8'h10, '0);
    set_b(1, 0, 8'h20, '0);
    for (int k = 0; k < 6; k++) begin
      exp_a = (k % 2 == 0);
      #3;
      checks++; if (a_gnt !== exp_a || b_gnt !== !exp_a) begin failures++; $display("FAIL b2b_gnt k=%0d got=%b%b exp=%b%b", k, a_gnt, b_gnt, exp_a, !exp_a); end
      if (k > 0) begin
        checks++; if (a_rvalid !== !exp_a || b_rvalid !== exp_a) begin failures++; $display("FAIL b2b_rvalid k=%0d got=%b%b exp=%b%b", k, a_rvalid, b_rvalid, !exp_a, exp_a); end
        checks++; if (exp_a ? (b_rdata !== 16'hB020) : (a_rdata !== 16'hA010)) begin failures++; $display("FAIL b2b_rdata k=%0d got=%h/%h", k, a_rdata, b_rdata); end
      end
      step();
    end
    set_a(0, 0, '0, '0);
    set_b(0, 0, '0, '0);
    #3;
    checks++; if (b_rvalid !== 1'b1 || b_rdata !== 16'hB020 || a_rvalid !== 1'b0) begin failures++; $display("FAIL b2b_last got=%b%b/%h exp=01/b020", a_rvalid, b_rvalid, b_rdata); end
    checks++; if (conflict_cnt !== 8'd6) begin failures++; $display("FAIL b2b_cnt got=%0d exp=6", conflict_cnt); end
    step();
  endtask

  task automatic test_raw_cross();
    do_reset();
    set_a(1, 1, 8'h07, 16'hBEEF);
    set_b(1, 0, 8'h07, '0);
    #3;
    checks++; if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin failures++; $display("FAIL raw_first got=%b%b exp=10", a_gnt, b_gnt); end
    step();
    set_a(0, 0, '0, '0);
    #3;
    checks++; if (b_gnt !== 1'b1 || a_gnt !== 1'b0) begin failures++; $display("FAIL raw_second got=%b%b exp=01", a_gnt, b_gnt); end
    step();
    set_b(0, 0, '0, '0);
    #3;
    checks++; if (b_rvalid !== 1'b1 || b_rdata !== 16'hBEEF) begin failures++; $display("FAIL raw_data got=%b/%h exp=1/beef", b_rvalid, b_rdata); end
    checks++; if (a_rvalid !== 1'b0) begin failures++; $display("FAIL raw_no_a_rvalid got=%b exp=0", a_rvalid); end
    step();
  endtask

  task automatic test_saturate();
    do_reset();
    set_a(1, 0, 8'h10, '0);
    set_b(1, 0, 8'h20, '0);
    for (int k = 0; k < 20; k++) begin
      #3;
      if (k == 14) begin
        checks++; if (conflict_cnt4 !== 4'd14) begin failures++; $display("FAIL sat_pre got=%0d exp=14", conflict_cnt4); end
      end
      step();
    end
    set_a(0, 0, '0, '0);
    set_b(0, 0, '0, '0);
    #3;
    checks++; if (conflict_cnt4 !== 4'd15) begin failures++; $display("FAIL sat_cw4 got=%0d exp=15", conflict_cnt4); end
    checks++; if (conflict_cnt !== 8'd20) begin failures++; $display("FAIL sat_cw8 got=%0d exp=20", conflict_cnt); end
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_a(1, 0, 8'h10, '0);
    set_b(1, 0, 8'h20, '0);
    step();
    set_a(0, 0, '0, '0);
    #3;
    checks++; if (b_gnt !== 1'b1) begin failures++; $display("FAIL mid_b_gnt got=%b exp=1", b_gnt); end
    step();
    #3;
    checks++; if (b_rvalid !== 1'b1 || b_rdata !== 16'hB020) begin failures++; $display("FAIL mid_b_first got=%b/%h exp=1/b020", b_rvalid, b_rdata); end
    checks++; if (b_gnt !== 1'b1) begin failures++; $display("FAIL mid_b_gnt2 got=%b exp=1", b_gnt); end
    rst_n = 1'b0;
    #1;
    checks++; if (b_rvalid !== 1'b0 || b_rdata !== 16'h0 || a_rdata !== 16'h0) begin failures++; $display("FAIL mid_rst_out got=%b/%h/%h exp=0/0000/0000", b_rvalid, b_rdata, a_rdata); end
    checks++; if (b_gnt !== 1'b0 || ram_en !== 1'b0 || conflict_cnt !== 8'd0) begin failures++; $display("FAIL mid_rst_ctl got=%b%b/%0d exp=00/0", b_gnt, ram_en, conflict_cnt); end
    step();
    #3;
    checks++; if (b_rvalid !== 1'b0) begin failures++; $display("FAIL mid_lost_rvalid got=%b exp=0", b_rvalid); end
    rst_n = 1'b1;
    set_a(1, 0, 8'h10, '0);
    #1;
    checks++; if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin failures++; $display("FAIL mid_tie_after got=%b%b exp=10", a_gnt, b_gnt); end
    step();
    set_a(0, 0, '0, '0);
    set_b(0, 0, '0, '0);
    step();
  endtask

  task automatic test_fixed_prio();
    logic exp_a;
    do_reset();
    set_a(1, 0, 8'h10, '0);
    set_b(1, 0, 8'h20, '0);
    for (int k = 0; k < 4; k++) begin
`ifdef DPRAM_ARB_FIXED_PRIO_EN
      exp_a = 1'b1;
`else
      exp_a = (k % 2 == 0);
`endif
      #3;
      checks++; if (a_gnt !== exp_a || b_gnt !== !exp_a) begin failures++; $display("FAIL prio_gnt k=%0d got=%b%b exp=%b%b", k, a_gnt, b_gnt, exp_a, !exp_a); end
      step();
    end
    set_a(0, 0, '0, '0);
    #3;
    checks++; if (b_gnt !== 1'b1) begin failures++; $display("FAIL prio_b_alone got=%b exp=1", b_gnt); end
    checks++; if (conflict_cnt !== 8'd4) begin failures++; $display("FAIL prio_cnt got=%0d exp=4", conflict_cnt); end
    step();
    set_b(0, 0, '0, '0);
    step();
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    mem[8'h10] = 16'hA010;
    mem[8'h20] = 16'hB020;
    ram_rdata = '0;
    rst_n = 1'b0;
    set_a(0, 0, '0, '0);
    set_b(0, 0, '0, '0);
    test_reset();
    test_write_read();
    test_back_to_back();
    test_raw_cross();
    test_saturate();
    test_reset_mid();
    test_fixed_prio();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
